// File: rtl/uart_rx_word_pkg.sv
// Shared constants, status layout and RX FSM encoding for the UART word receiver.
package uart_rx_word_pkg;

    localparam logic [31:0] RX_STAT_ADDR = 32'h3000_0008;
    localparam logic [31:0] RX_DATA_ADDR = 32'h3000_000C;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam int unsigned ST_AVAIL   = 0;
    localparam int unsigned ST_OVR     = 1;
    localparam int unsigned ST_FRM     = 2;
    localparam int unsigned ST_CNT_LSB = 3;
    localparam int unsigned ST_FLUSH   = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_e;

    // Status register image as seen on a read of the status address.
    typedef struct packed {
        logic [22:0] rsvd;
        logic [3:0]  fifo_cnt;
        logic [1:0]  byte_cnt;
        logic        frm_err;
        logic        ovr_err;
        logic        avail;
    } rx_stat_t;

endpackage

// File: rtl/uart_rx_word_fifo.sv
// Synchronous word FIFO with flush; pointers carry one wrap bit for full/empty.
module uart_rx_word_fifo
    import uart_rx_word_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // A pop on an empty FIFO is ignored; a push into a full FIFO needs a same-cycle pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs bytes little-endian into 32-bit words behind
// memory-mapped status/data registers.
module uart_rx_word
    import uart_rx_word_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] STAT_ADDR  = RX_STAT_ADDR,
    parameter logic [31:0] DATA_ADDR  = RX_DATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        rx_avail_o
);

    localparam int unsigned CW  = $clog2(BAUD_DIV);
    localparam int unsigned FAW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    logic              rx_meta;
    logic              rx_s;
    logic              rx_hi;
    logic [1:0]        settle;

    rx_state_e         state;
    rx_state_e         state_nxt;
    logic [CW-1:0]     baud_cnt;
    logic [CW-1:0]     baud_cnt_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_nxt;
    logic [7:0]        shreg;
    logic [7:0]        shreg_nxt;
    logic              byte_vld_c;
    logic              frm_set_c;

    logic [1:0]        byte_cnt;
    logic [23:0]       word_acc;
    logic              ovr_err;
    logic              frm_err;

    logic              stat_rd_c;
    logic              data_rd_c;
    logic              stat_wr_c;
    logic              flush_c;
    logic              ovr_clr_c;
    logic              frm_clr_c;
    logic              push_c;
    logic              pop_c;
    logic              ovr_set_c;

    logic [WORD_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FAW:0]      fifo_cnt;
    rx_stat_t          stat_c;
    logic              unused_wdata;

    // Synchroniser; rx_hi only reflects samples taken after reset has flushed the
    // synchroniser, so a line held low across reset release is not seen as a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            settle  <= 2'b00;
            rx_hi   <= 1'b0;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            settle  <= {settle[0], 1'b1};
            rx_hi   <= settle[1] & rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt + CNT_ONE;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        byte_vld_c   = 1'b0;
        frm_set_c    = 1'b0;
        unique case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                if (rx_hi && !rx_s) begin
                    state_nxt   = START;
                    bit_idx_nxt = '0;
                end
            end
            START: begin
                if (baud_cnt == CNT_HALF) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_nxt = '0;
                    shreg_nxt    = {rx_s, shreg[7:1]};
                    bit_idx_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_nxt = '0;
                    if (rx_s) begin
                        byte_vld_c = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        frm_set_c  = 1'b1;
                        state_nxt  = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                baud_cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stat_rd_c = mem_req_i && !mem_we_i && (mem_addr_i == STAT_ADDR);
    assign data_rd_c = mem_req_i && !mem_we_i && (mem_addr_i == DATA_ADDR);
    assign stat_wr_c = mem_req_i &&  mem_we_i && (mem_addr_i == STAT_ADDR);
    assign flush_c   = stat_wr_c && mem_wdata_i[ST_FLUSH];
    assign ovr_clr_c = stat_wr_c && mem_wdata_i[ST_OVR];
    assign frm_clr_c = stat_wr_c && mem_wdata_i[ST_FRM];
    assign unused_wdata = ^{mem_wdata_i[31:4], mem_wdata_i[ST_AVAIL]};

    assign pop_c     = data_rd_c && !fifo_empty;
    assign push_c    = byte_vld_c && (byte_cnt == 2'd3) && !flush_c;
    assign ovr_set_c = push_c && fifo_full && !pop_c;

    // Packer and sticky error flags; a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            word_acc <= '0;
            ovr_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            if (flush_c) begin
                byte_cnt <= '0;
            end else if (byte_vld_c) begin
                case (byte_cnt)
                    2'd0:    word_acc[7:0]   <= shreg;
                    2'd1:    word_acc[15:8]  <= shreg;
                    2'd2:    word_acc[23:16] <= shreg;
                    default: word_acc        <= word_acc;
                endcase
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (ovr_set_c)      ovr_err <= 1'b1;
            else if (ovr_clr_c) ovr_err <= 1'b0;
            if (frm_set_c)      frm_err <= 1'b1;
            else if (frm_clr_c) frm_err <= 1'b0;
        end
    end

    uart_rx_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .flush (flush_c),
        .wdata ({shreg, word_acc}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        stat_c          = '0;
        stat_c.avail    = !fifo_empty;
        stat_c.ovr_err  = ovr_err;
        stat_c.frm_err  = frm_err;
        stat_c.byte_cnt = byte_cnt;
        stat_c.fifo_cnt = 4'(fifo_cnt);
    end

    // Read data is combinational so a data read pops on the same edge it returns.
    always_comb begin
        mem_rdata_o = '0;
        if (stat_rd_c)                     mem_rdata_o = stat_c;
        else if (data_rd_c && !fifo_empty) mem_rdata_o = head;
    end

    assign rx_avail_o = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word with a queue-based reference model.
module tb_uart_rx_word;

    localparam int unsigned BAUD  = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] STAT  = 32'h3000_0008;
    localparam logic [31:0] DATA  = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_i = 1'b1;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        rx_avail_o;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [31:0] q_words[$];
    int          m_cnt = 0;
    logic [31:0] m_acc = '0;
    bit          m_ovr = 1'b0;
    bit          m_frm = 1'b0;
    bit          mon_rd = 1'b0;
    bit          quiet = 1'b0;

    always #5 clk = ~clk;

    uart_rx_word #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH),
        .STAT_ADDR  (STAT),
        .DATA_ADDR  (DATA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .rx_avail_o  (rx_avail_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic logic [31:0] model_stat();
        return {23'd0, 4'(q_words.size()), 2'(m_cnt), m_frm, m_ovr, q_words.size() != 0};
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] addr);
        if (addr == STAT) return model_stat();
        if (addr == DATA && q_words.size() != 0) return q_words[0];
        return 32'd0;
    endfunction

    task automatic model_reset();
        q_words.delete();
        m_cnt = 0;
        m_acc = '0;
        m_ovr = 1'b0;
        m_frm = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [31:0] w;
        if (m_cnt == 3) begin
            w = {b, m_acc[23:0]};
            if (q_words.size() < DEPTH) q_words.push_back(w);
            else m_ovr = 1'b1;
            m_cnt = 0;
            m_acc = '0;
        end else begin
            m_acc[8*m_cnt +: 8] = b;
            m_cnt++;
        end
    endtask

    // Continuous comparison against the model whenever the bus reads or the line is quiet.
    always @(negedge clk) begin
        if (rst) begin
            if (mon_rd) check("rdata_vs_model", mem_rdata_o, model_rdata(mem_addr_i));
            if (quiet)  check("avail_vs_model", {31'd0, rx_avail_o}, {31'd0, q_words.size() != 0});
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        quiet = 1'b0;
        @(posedge clk); #1 rx_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(posedge clk);
            #1 rx_i = b[i];
        end
        repeat (BAUD) @(posedge clk);
        #1 rx_i = stop_ok;
        repeat (BAUD) @(posedge clk);
        if (!stop_ok) begin
            repeat (12) @(posedge clk);
            #1 rx_i = 1'b1;
            repeat (6) @(posedge clk);
            m_frm = 1'b1;
        end else begin
            #1 model_byte(b);
        end
        repeat (3) @(posedge clk);
        quiet = 1'b1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge clk);
        #1 mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = addr; mon_rd = 1'b1;
        @(negedge clk);
        data = mem_rdata_o;
        @(posedge clk);
        #1 mem_req_i = 1'b0; mon_rd = 1'b0;
        if (addr == DATA && q_words.size() != 0) void'(q_words.pop_front());
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1 mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = addr; mem_wdata_i = data;
        @(posedge clk);
        #1 mem_req_i = 1'b0; mem_we_i = 1'b0;
        if (addr == STAT) begin
            if (data[1]) m_ovr = 1'b0;
            if (data[2]) m_frm = 1'b0;
            if (data[3]) begin
                q_words.delete();
                m_cnt = 0;
                m_acc = '0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        // Reset state, checked while reset is held.
        #1 mem_req_i = 1'b1; mem_addr_i = STAT;
        repeat (3) @(posedge clk);
        #1 check("rst_rdata", mem_rdata_o, 32'd0);
        check("rst_avail", {31'd0, rx_avail_o}, 32'd0);
        mem_req_i = 1'b0;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        quiet = 1'b1;

        // Four bytes pack little-endian into one word.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        bus_read(STAT, d);           check("t1_stat", d, 32'h0000_0021);
        bus_write(DATA, 32'hFFFF_FFFF);
        bus_read(STAT, d);           check("t1_stat_after_dwr", d, 32'h0000_0021);
        bus_read(32'h3000_0004, d);  check("t1_other_addr", d, 32'd0);
        bus_read(DATA, d);           check("t1_word", d, 32'h4433_2211);
        bus_read(STAT, d);           check("t1_stat_empty", d, 32'd0);
        bus_read(DATA, d);           check("t1_empty_data", d, 32'd0);

        // Five words into a four-deep FIFO with no reads: last word dropped.
        for (int i = 0; i < 20; i++) send_byte(8'(i + 1), 1'b1);
        bus_read(STAT, d);           check("t2_stat_ovr", d, 32'h0000_0083);
        bus_read(DATA, d);           check("t2_w1", d, 32'h0403_0201);
        bus_read(DATA, d);           check("t2_w2", d, 32'h0807_0605);
        bus_read(DATA, d);           check("t2_w3", d, 32'h0C0B_0A09);
        bus_read(DATA, d);           check("t2_w4", d, 32'h100F_0E0D);
        bus_read(STAT, d);           check("t2_stat_drained", d, 32'h0000_0002);
        bus_write(STAT, 32'h2);
        bus_read(STAT, d);           check("t2_stat_clr", d, 32'd0);

        // Framing error, recovery and clear.
        send_byte(8'hA5, 1'b0);
        bus_read(STAT, d);           check("t3_frm", d, 32'h0000_0004);
        send_byte(8'h5A, 1'b1);
        bus_read(STAT, d);           check("t3_good_byte", d, 32'h0000_000C);
        bus_write(STAT, 32'h4);
        bus_read(STAT, d);           check("t3_frm_clr", d, 32'h0000_0008);
        bus_write(STAT, 32'h8);
        bus_read(STAT, d);           check("t3_flush", d, 32'd0);

        // Short low glitch is a false start.
        @(posedge clk); #1 rx_i = 1'b0;
        repeat (BAUD / 4) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (20) @(posedge clk);
        bus_read(STAT, d);           check("t4_glitch", d, 32'd0);

        // Flush of a partial word, then reset mid-byte.
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        bus_read(STAT, d);           check("t5_two_bytes", d, 32'h0000_0010);
        bus_write(STAT, 32'h8);
        bus_read(STAT, d);           check("t5_flushed", d, 32'd0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        quiet = 1'b0;
        @(posedge clk); #1 rx_i = 1'b0;
        repeat (30) @(posedge clk);
        #1 mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = STAT;
        #1 check("t5_pre_rst", mem_rdata_o, 32'h0000_0021);
        rst = 1'b0;
        #1 check("t5_rst_rdata", mem_rdata_o, 32'd0);
        check("t5_rst_avail", {31'd0, rx_avail_o}, 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 mem_req_i = 1'b0;
        rst = 1'b1;
        repeat (100) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (20) @(posedge clk);
        quiet = 1'b1;
        bus_read(STAT, d);           check("t5_low_after_rst", d, 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        send_byte(8'h45, 1'b1);
        send_byte(8'h67, 1'b1);
        bus_read(STAT, d);           check("t5_stat_after_rst", d, 32'h0000_0021);
        bus_read(DATA, d);           check("t5_word_after_rst", d, 32'h6745_2301);

        // Full FIFO with a pop on the same edge as the next word's push.
        for (int i = 0; i < 16; i++) send_byte(8'(8'h60 + i), 1'b1);
        send_byte(8'hD1, 1'b1);
        send_byte(8'hD2, 1'b1);
        send_byte(8'hD3, 1'b1);
        fork
            send_byte(8'hD4, 1'b1);
            begin
                logic [31:0] rd;
                @(posedge clk);
                repeat (BAUD * 10 - 3) @(posedge clk);
                bus_read(DATA, rd);
                check("t6_concurrent_pop", rd, 32'h6362_6160);
            end
        join
        bus_read(STAT, d);           check("t6_stat", d, 32'h0000_0081);
        bus_read(DATA, d);           check("t6_w2", d, 32'h6766_6564);
        bus_read(DATA, d);           check("t6_w3", d, 32'h6B6A_6968);
        bus_read(DATA, d);           check("t6_w4", d, 32'h6F6E_6D6C);
        bus_read(DATA, d);           check("t6_w5", d, 32'hD4D3_D2D1);
        bus_read(STAT, d);           check("t6_stat_end", d, 32'd0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Receive-side counterpart of the core's UART transmit path.
- Deserialises 8N1 bytes from the rx pin and packs four bytes, little-endian, into 32-bit words.
- Buffers the words in a small FIFO.
- The core reads them through memory-mapped status/data registers on the ex-stage memory request bus, polling the same way it polls the TX status register.

Parameters:
- BAUD_DIV, 434: clk cycles per bit (50 MHz / 115200); must be >= 4.
- FIFO_DEPTH, 4: number of 32-bit word entries; power of two.
- STAT_ADDR, 32'h30000008: RX status register address.
- DATA_ADDR, 32'h3000000C: RX data register address.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (`RstEnable = 0); all state clears immediately on assertion.
- rx_i  in  1  UART serial input, asynchronous, idle high.
- mem_req_i  in  1  ex-stage memory access request.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_addr_i  in  32  access address.
- mem_wdata_i  in  32  write data.
- mem_rdata_o  out  32  read data, combinational; 0 when the address does not match.
- rx_avail_o  out  1  FIFO non-empty; optional interrupt.

Behaviour:
- Reset values: mem_rdata_o = 0, rx_avail_o = 0; FSM in IDLE; FIFO empty; packer byte_cnt = 0; sticky flags 0; synchroniser flops = 1.
- rx_i goes through a 2-flop synchroniser (rx_s) before any use.
- FSM states and transitions:
  - IDLE: falling edge of rx_s -> START, bit counter cleared.
  - START: wait BAUD_DIV/2 cycles, then sample. rx_s = 0 -> DATA. rx_s = 1 -> false start, back to IDLE, nothing recorded.
  - DATA: every BAUD_DIV cycles sample one bit, LSB first. After 8 bits -> STOP.
  - STOP: wait BAUD_DIV cycles, then sample. rx_s = 1 -> byte valid for one cycle, then IDLE. rx_s = 0 -> set frm_err sticky, discard byte, go to WAIT_HI.
  - WAIT_HI: stay until rx_s = 1, then IDLE (prevents a break condition retriggering).
- Packer:
  - A valid byte lands in word[8*byte_cnt +: 8] and byte_cnt increments.
  - When byte_cnt = 3 the completed word is pushed and byte_cnt wraps to 0.
  - If the FIFO is full and no pop happens that cycle, the word is dropped and ovr_err is set sticky.
- FIFO: pointers of log2(FIFO_DEPTH)+1 bits; full and empty derived from pointer MSB comparison.
- Status read (req = 1, we = 0, addr = STAT_ADDR) returns:
  - bit0 avail
  - bit1 ovr_err
  - bit2 frm_err
  - bits[4:3] byte_cnt
  - bits[8:5] FIFO count, zero-extended
  - remaining bits 0
- Data read (req = 1, we = 0, addr = DATA_ADDR):
  - Non-empty FIFO: returns the head word combinationally and pops on the same clk edge.
  - Empty FIFO: returns 0, no pop, no error.
- Status write (req = 1, we = 1, addr = STAT_ADDR):
  - bit1 = 1 clears ovr_err; bit2 = 1 clears frm_err (write-1-to-clear).
  - bit3 = 1 flushes: FIFO emptied, byte_cnt = 0. The RX FSM is not disturbed.
- Simultaneous events:
  - Push and pop in the same cycle when full: both occur, count unchanged, no overrun.
  - Push and pop when empty: the word is pushed and the pop is ignored (the read already returned 0).
  - Flush together with a push: flush wins and the pushed word is discarded.
  - Error clear together with a new error event: the set wins.
- Writes to DATA_ADDR and accesses to any other address have no effect.
- Reset asserted mid-frame: immediate return to reset values; the partial byte is lost. After release, an rx line that is low waits in IDLE for the next falling edge.

Decomposition:
- Shared package/defines:
  - RX register addresses.
  - Status bit indices (ST_AVAIL = 0, ST_OVR = 1, ST_FRM = 2, ST_CNT_LSB = 3, ST_FLUSH = 3).
  - FSM state encodings (IDLE, START, DATA, STOP, WAIT_HI; 3-bit).
- One natural sub-module: uart_rx_word_fifo, a synchronous word FIFO with push, pop, flush, full, empty and count outputs.
- Bit timing, packer and register decode stay in the top module.

Test Plan:
- Send bytes 0x11, 0x22, 0x33, 0x44 at BAUD_DIV = 8 -> status reads 0x00000021 (avail = 1, count = 1, byte_cnt = 0); data read returns 0x44332211; next status reads 0x00000000.
- Send 20 bytes (5 words) with FIFO_DEPTH = 4 and no reads -> status bit1 = 1, count = 4; reads return words 1 to 4; write 0x2 to status clears bit1.
- Send 0xA5 with the stop bit held low -> status bit2 = 1, byte_cnt = 0; rx returns high, then a good byte 0x5A -> byte_cnt = 1; write 0x4 clears bit2.
- Low glitch on rx_i of BAUD_DIV/4 cycles -> FSM returns to IDLE; status unchanged (0x00000000).
- Two bytes received, then write 0x8 to status -> byte_cnt = 0 and FIFO empty. Then assert rst mid-byte -> rx_avail_o = 0 and mem_rdata_o = 0 immediately; the next full 4-byte frame is received correctly.
- FIFO full, with a data-register read on the same cycle the 4th byte of a new word completes -> no overrun, count stays 4, read order preserved.
